// File: rtl/id_issue_ctrl_if.sv
// Decode-slot bundle between the uop FIFO heads and the issue controller.
// The decoder side is master; the controller side is slave and returns read_en.
interface id_issue_ctrl_if;
    logic       valid0, valid1;
    logic [1:0] cls0, cls1;
    logic       wr0, wr1;
    logic       use_j0, use_k0, use_j1, use_k1;
    logic [4:0] rd0, rj0, rk0, rd1, rj1, rk1;
    logic [6:0] exc0, exc1;
    logic [1:0] read_en;
    logic       issue0, issue1;

    modport master (
        output valid0, valid1, cls0, cls1, wr0, wr1,
               use_j0, use_k0, use_j1, use_k1,
               rd0, rj0, rk0, rd1, rj1, rk1, exc0, exc1,
        input  read_en, issue0, issue1
    );

    modport slave (
        input  valid0, valid1, cls0, cls1, wr0, wr1,
               use_j0, use_k0, use_j1, use_k1,
               rd0, rj0, rk0, rd1, rj1, rk1, exc0, exc1,
        output read_en, issue0, issue1
    );
endinterface

// File: rtl/id_issue_ctrl.sv
// Dual-issue scheduler: pair hazards, long-latency register scoreboard, in-flight memory bound.
// Optional issue statistics counters are built when ISSUE_STAT_EN is defined.
module id_issue_ctrl #(
    parameter int unsigned MEM_MAX = 2,
    parameter int unsigned NREG    = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            ex_ready,
    id_issue_ctrl_if.slave  dec,
    input  logic            wb_valid0,
    input  logic            wb_valid1,
    input  logic [4:0]      wb_rd0,
    input  logic [4:0]      wb_rd1,
    input  logic [1:0]      mem_done,
    output logic [NREG-1:0] busy_vec
`ifdef ISSUE_STAT_EN
    ,
    output logic [31:0]     cnt_dual,
    output logic [31:0]     cnt_single,
    output logic [31:0]     cnt_stall
`endif
);

    typedef enum logic [1:0] {
        CLS_ALU    = 2'b00,
        CLS_MEM    = 2'b01,
        CLS_MULDIV = 2'b10,
        CLS_BRANCH = 2'b11
    } cls_e;

    localparam logic [2:0] MEM_LIMIT = 3'(MEM_MAX);

    logic [NREG-1:0] r_busy;
    logic [2:0]      r_mem_cnt;

    logic [NREG-1:0] w_wb_mask;
    logic [NREG-1:0] w_busy_eff;
    logic [NREG-1:0] w_set_mask;
    logic [2:0]      w_mem_cnt_eff;
    logic [2:0]      w_mem_iss;
    logic            w_mem_room;
    logic            w_sb0, w_sb1;
    logic            w_raw, w_waw, w_pair_cls;
    logic            w_ok0, w_ok1;

    function automatic logic sb_hit(input logic [NREG-1:0] be, input logic use_r,
                                    input logic [4:0] r);
        return use_r & be[r];
    endfunction

    function automatic logic long_lat(input logic [1:0] c);
        return (c == CLS_MEM) || (c == CLS_MULDIV);
    endfunction

    // Writebacks in the current cycle release their register for issue right away.
    always_comb begin
        w_wb_mask = '0;
        if (wb_valid0) w_wb_mask[wb_rd0] = 1'b1;
        if (wb_valid1) w_wb_mask[wb_rd1] = 1'b1;
        w_busy_eff    = r_busy & ~w_wb_mask;
        w_busy_eff[0] = 1'b0;
    end

    assign w_mem_cnt_eff = r_mem_cnt - {1'b0, mem_done};
    assign w_mem_room    = (w_mem_cnt_eff < MEM_LIMIT);

    assign w_sb0 = sb_hit(w_busy_eff, dec.use_j0, dec.rj0) |
                   sb_hit(w_busy_eff, dec.use_k0, dec.rk0) |
                   sb_hit(w_busy_eff, dec.wr0,    dec.rd0);
    assign w_sb1 = sb_hit(w_busy_eff, dec.use_j1, dec.rj1) |
                   sb_hit(w_busy_eff, dec.use_k1, dec.rk1) |
                   sb_hit(w_busy_eff, dec.wr1,    dec.rd1);

    assign w_raw = dec.wr0 && (dec.rd0 != 5'd0) &&
                   ((dec.use_j1 && (dec.rj1 == dec.rd0)) ||
                    (dec.use_k1 && (dec.rk1 == dec.rd0)));
    assign w_waw = dec.wr0 && dec.wr1 && (dec.rd0 == dec.rd1) && (dec.rd0 != 5'd0);
    assign w_pair_cls = (dec.cls0 == dec.cls1) && long_lat(dec.cls0);

    always_comb begin
        w_ok0 = rstn && dec.valid0 && ex_ready && !flush && !w_sb0 &&
                ((dec.cls0 != CLS_MEM) || w_mem_room);
        w_ok1 = w_ok0 && dec.valid1 &&
                (dec.exc0 == 7'd0) && (dec.exc1 == 7'd0) &&
                (dec.cls0 != CLS_BRANCH) && !w_pair_cls &&
                !w_raw && !w_waw && !w_sb1 &&
                ((dec.cls1 != CLS_MEM) || w_mem_room);
    end

    assign dec.read_en = {w_ok1, w_ok0};
    assign dec.issue0  = w_ok0;
    assign dec.issue1  = w_ok1;

    always_comb begin
        w_set_mask = '0;
        if (w_ok0 && dec.wr0 && (dec.rd0 != 5'd0) && long_lat(dec.cls0))
            w_set_mask[dec.rd0] = 1'b1;
        if (w_ok1 && dec.wr1 && (dec.rd1 != 5'd0) && long_lat(dec.cls1))
            w_set_mask[dec.rd1] = 1'b1;
    end

    // At most one memory uop issues per cycle since a mem/mem pair never dual-issues.
    assign w_mem_iss = 3'(w_ok0 && (dec.cls0 == CLS_MEM)) +
                       3'(w_ok1 && (dec.cls1 == CLS_MEM));

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            r_busy    <= '0;
            r_mem_cnt <= '0;
        end else begin
            r_busy    <= w_busy_eff | w_set_mask;
            r_mem_cnt <= w_mem_cnt_eff + w_mem_iss;
        end
    end

    assign busy_vec = r_busy;

    a_mem_no_underflow: assert property (
        @(posedge clk) disable iff (!rstn || flush) ({1'b0, mem_done} <= r_mem_cnt)
    );

`ifdef ISSUE_STAT_EN
    logic [31:0] r_cnt_dual, r_cnt_single, r_cnt_stall;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt_dual   <= '0;
            r_cnt_single <= '0;
            r_cnt_stall  <= '0;
        end else if (!flush && dec.valid0) begin
            case ({w_ok1, w_ok0})
                2'b11:   r_cnt_dual   <= r_cnt_dual + 32'd1;
                2'b01:   r_cnt_single <= r_cnt_single + 32'd1;
                default: r_cnt_stall  <= r_cnt_stall + 32'd1;
            endcase
        end
    end

    assign cnt_dual   = r_cnt_dual;
    assign cnt_single = r_cnt_single;
    assign cnt_stall  = r_cnt_stall;
`endif

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed self-checking bench for id_issue_ctrl: pair rules, scoreboard, memory bound, flush/reset.
module tb_id_issue_ctrl;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        ex_ready;
    logic        wb_valid0, wb_valid1;
    logic [4:0]  wb_rd0, wb_rd1;
    logic [1:0]  mem_done;
    logic [31:0] busy_vec;
`ifdef ISSUE_STAT_EN
    logic [31:0] cnt_dual, cnt_single, cnt_stall;
`endif

    int checks   = 0;
    int failures = 0;

    id_issue_ctrl_if dif ();

    id_issue_ctrl #(.MEM_MAX(2), .NREG(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .ex_ready  (ex_ready),
        .dec       (dif),
        .wb_valid0 (wb_valid0),
        .wb_valid1 (wb_valid1),
        .wb_rd0    (wb_rd0),
        .wb_rd1    (wb_rd1),
        .mem_done  (mem_done),
        .busy_vec  (busy_vec)
`ifdef ISSUE_STAT_EN
        ,
        .cnt_dual  (cnt_dual),
        .cnt_single(cnt_single),
        .cnt_stall (cnt_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [1:0] c, input logic w, input logic [4:0] rd,
                          input logic uj, input logic [4:0] rj, input logic uk, input logic [4:0] rk);
        dif.valid0 = v; dif.cls0 = c; dif.wr0 = w; dif.rd0 = rd;
        dif.use_j0 = uj; dif.rj0 = rj; dif.use_k0 = uk; dif.rk0 = rk;
    endtask

    task automatic drive1(input logic v, input logic [1:0] c, input logic w, input logic [4:0] rd,
                          input logic uj, input logic [4:0] rj, input logic uk, input logic [4:0] rk);
        dif.valid1 = v; dif.cls1 = c; dif.wr1 = w; dif.rd1 = rd;
        dif.use_j1 = uj; dif.rj1 = rj; dif.use_k1 = uk; dif.rk1 = rk;
    endtask

    task automatic idle();
        drive0(1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        drive1(1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        dif.exc0 = 7'd0; dif.exc1 = 7'd0;
        flush = 1'b0; ex_ready = 1'b1;
        wb_valid0 = 1'b0; wb_valid1 = 1'b0; wb_rd0 = 5'd0; wb_rd1 = 5'd0;
        mem_done = 2'd0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle();
        drive0(1'b1, 2'b00, 1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        tick();
        checks++;
        if (dif.read_en !== 2'b00) begin
            failures++; $display("FAIL reset_read_en got=%b exp=00", dif.read_en);
        end
        checks++;
        if (busy_vec !== 32'h0) begin
            failures++; $display("FAIL reset_busy got=%h exp=00000000", busy_vec);
        end
        rstn = 1'b1;
        idle();
        tick();
    endtask

    task automatic test_alu_pair();
        drive0(1'b1, 2'b00, 1'b1, 5'd1, 1'b1, 5'd4, 1'b0, 5'd0);
        drive1(1'b1, 2'b00, 1'b1, 5'd6, 1'b1, 5'd2, 1'b1, 5'd3);
        #1;
        checks++;
        if (dif.read_en !== 2'b11 || dif.issue0 !== 1'b1 || dif.issue1 !== 1'b1) begin
            failures++; $display("FAIL alu_pair got=%b/%b%b exp=11/11", dif.read_en, dif.issue1, dif.issue0);
        end
        tick();
        checks++;
        if (dif.read_en !== 2'b11) begin
            failures++; $display("FAIL alu_pair_2nd got=%b exp=11", dif.read_en);
        end
        tick();
        checks++;
        if (busy_vec !== 32'h0) begin
            failures++; $display("FAIL alu_pair_busy got=%h exp=00000000", busy_vec);
        end
        idle();
    endtask

    task automatic test_raw_waw();
        drive0(1'b1, 2'b00, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        drive1(1'b1, 2'b00, 1'b1, 5'd8, 1'b1, 5'd5, 1'b0, 5'd0);
        #1;
        checks++;
        if (dif.read_en !== 2'b01 || dif.issue1 !== 1'b0) begin
            failures++; $display("FAIL raw_pair got=%b exp=01", dif.read_en);
        end
        tick();
        drive0(1'b1, 2'b00, 1'b1, 5'd8, 1'b1, 5'd5, 1'b0, 5'd0);
        drive1(1'b1, 2'b00, 1'b1, 5'd9, 1'b1, 5'd10, 1'b0, 5'd0);
        #1;
        checks++;
        if (dif.read_en !== 2'b11) begin
            failures++; $display("FAIL raw_shifted got=%b exp=11", dif.read_en);
        end
        drive0(1'b1, 2'b00, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0);
        drive1(1'b1, 2'b00, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0);
        #1;
        checks++;
        if (dif.read_en !== 2'b01) begin
            failures++; $display("FAIL waw_pair got=%b exp=01", dif.read_en);
        end
        drive0(1'b1, 2'b00, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        drive1(1'b1, 2'b00, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
        #1;
        checks++;
        if (dif.read_en !== 2'b11) begin
            failures++; $display("FAIL r0_no_hazard got=%b exp=11", dif.read_en);
        end
        idle();
        tick();
    endtask

    task automatic test_pair_rules();
        drive0(1'b1, 2'b11, 1'b0, 5'd0, 1'b1, 5'd1, 1'b0, 5'd0);
        drive1(1'b1, 2'b00, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0);
        #1;
        checks++;
        if (dif.read_en !== 2'b01) begin
            failures++; $display("FAIL branch_slot0 got=%b exp=01", dif.read_en);
        end
        dif.cls0 = 2'b00;
        dif.exc1 = 7'h0B;
        #1;
        checks++;
        if (dif.read_en !== 2'b01) begin
            failures++; $display("FAIL exc1 got=%b exp=01", dif.read_en);
        end
        dif.exc1 = 7'd0;
        dif.exc0 = 7'h01;
        #1;
        checks++;
        if (dif.read_en !== 2'b01) begin
            failures++; $display("FAIL exc0 got=%b exp=01", dif.read_en);
        end
        dif.exc0 = 7'd0;
        dif.cls0 = 2'b10;
        dif.cls1 = 2'b10;
        dif.wr1  = 1'b0;
        #1;
        checks++;
        if (dif.read_en !== 2'b01) begin
            failures++; $display("FAIL muldiv_pair got=%b exp=01", dif.read_en);
        end
        dif.cls1 = 2'b00;
        #1;
        checks++;
        if (dif.read_en !== 2'b11) begin
            failures++; $display("FAIL muldiv_alu got=%b exp=11", dif.read_en);
        end
        ex_ready = 1'b0;
        #1;
        checks++;
        if (dif.read_en !== 2'b00) begin
            failures++; $display("FAIL ex_not_ready got=%b exp=00", dif.read_en);
        end
        ex_ready   = 1'b1;
        dif.valid0 = 1'b0;
        #1;
        checks++;
        if (dif.read_en !== 2'b00) begin
            failures++; $display("FAIL slot0_empty got=%b exp=00", dif.read_en);
        end
        idle();
        tick();
    endtask

    task automatic test_scoreboard();
        drive0(1'b1, 2'b01, 1'b1, 5'd7, 1'b1, 5'd1, 1'b0, 5'd0);
        #1;
        checks++;
        if (dif.read_en !== 2'b01) begin
            failures++; $display("FAIL load_issue got=%b exp=01", dif.read_en);
        end
        tick();
        checks++;
        if (busy_vec !== 32'h0000_0080) begin
            failures++; $display("FAIL load_busy got=%h exp=00000080", busy_vec);
        end
        drive0(1'b1, 2'b00, 1'b1, 5'd2, 1'b1, 5'd1, 1'b0, 5'd0);
        drive1(1'b1, 2'b00, 1'b1, 5'd3, 1'b1, 5'd7, 1'b0, 5'd0);
        #1;
        checks++;
        if (dif.read_en !== 2'b01) begin
            failures++; $display("FAIL sb_slot1 got=%b exp=01", dif.read_en);
        end
        drive1(1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        drive0(1'b1, 2'b00, 1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 5'd7);
        #1;
        checks++;
        if (dif.read_en !== 2'b00) begin
            failures++; $display("FAIL sb_stall got=%b exp=00", dif.read_en);
        end
        tick();
        checks++;
        if (dif.read_en !== 2'b00 || busy_vec !== 32'h0000_0080) begin
            failures++; $display("FAIL sb_stall_hold got=%b/%h exp=00/00000080", dif.read_en, busy_vec);
        end
        wb_valid0 = 1'b1; wb_rd0 = 5'd7; mem_done = 2'd1;
        #1;
        checks++;
        if (dif.read_en !== 2'b01) begin
            failures++; $display("FAIL wb_bypass got=%b exp=01", dif.read_en);
        end
        tick();
        checks++;
        if (busy_vec !== 32'h0) begin
            failures++; $display("FAIL wb_clear got=%h exp=00000000", busy_vec);
        end
        idle();
    endtask

    task automatic test_mem_limit();
        drive0(1'b1, 2'b01, 1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd0);
        #1;
        checks++;
        if (dif.read_en !== 2'b01) begin
            failures++; $display("FAIL mem_first got=%b exp=01", dif.read_en);
        end
        tick();
        dif.rd0 = 5'd11;
        #1;
        checks++;
        if (dif.read_en !== 2'b01) begin
            failures++; $display("FAIL mem_second got=%b exp=01", dif.read_en);
        end
        tick();
        dif.rd0 = 5'd12;
        #1;
        checks++;
        if (dif.read_en !== 2'b00) begin
            failures++; $display("FAIL mem_third_stall got=%b exp=00", dif.read_en);
        end
        tick();
        mem_done = 2'd1;
        #1;
        checks++;
        if (dif.read_en !== 2'b01) begin
            failures++; $display("FAIL mem_done_bypass got=%b exp=01", dif.read_en);
        end
        tick();
        mem_done = 2'd0;
        dif.rd0  = 5'd13;
        #1;
        checks++;
        if (dif.read_en !== 2'b00 || busy_vec !== 32'h0000_1C00) begin
            failures++; $display("FAIL mem_cnt_held got=%b/%h exp=00/00001c00", dif.read_en, busy_vec);
        end
        idle();
        mem_done = 2'd2;
        wb_valid0 = 1'b1; wb_rd0 = 5'd10; wb_valid1 = 1'b1; wb_rd1 = 5'd11;
        tick();
        mem_done = 2'd0;
        wb_rd0 = 5'd12; wb_valid1 = 1'b0;
        tick();
        checks++;
        if (busy_vec !== 32'h0) begin
            failures++; $display("FAIL mem_drain got=%h exp=00000000", busy_vec);
        end
        idle();
    endtask

    task automatic test_flush_reset();
        drive0(1'b1, 2'b01, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        drive0(1'b1, 2'b00, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0);
        flush = 1'b1;
        wb_valid0 = 1'b1; wb_rd0 = 5'd3; mem_done = 2'd1;
        #1;
        checks++;
        if (dif.read_en !== 2'b00 || busy_vec !== 32'h0000_0080) begin
            failures++; $display("FAIL flush_cycle got=%b/%h exp=00/00000080", dif.read_en, busy_vec);
        end
        tick();
        idle();
        #1;
        checks++;
        if (busy_vec !== 32'h0) begin
            failures++; $display("FAIL flush_busy got=%h exp=00000000", busy_vec);
        end
        drive0(1'b1, 2'b01, 1'b1, 5'd20, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        dif.rd0 = 5'd21;
        #1;
        checks++;
        if (dif.read_en !== 2'b01) begin
            failures++; $display("FAIL flush_memcnt got=%b exp=01", dif.read_en);
        end
        tick();
        rstn = 1'b0;
        dif.rd0 = 5'd22;
        #1;
        checks++;
        if (dif.read_en !== 2'b00) begin
            failures++; $display("FAIL midreset_read_en got=%b exp=00", dif.read_en);
        end
        tick();
        rstn = 1'b1;
        dif.rd0 = 5'd23;
        #1;
        checks++;
        if (busy_vec !== 32'h0 || dif.read_en !== 2'b01) begin
            failures++; $display("FAIL midreset_state got=%h/%b exp=00000000/01", busy_vec, dif.read_en);
        end
        tick();
        dif.rd0 = 5'd24;
        #1;
        checks++;
        if (dif.read_en !== 2'b01) begin
            failures++; $display("FAIL midreset_memcnt got=%b exp=01", dif.read_en);
        end
        tick();
        idle();
    endtask

    initial begin
        test_reset();
        test_alu_pair();
        test_raw_waw();
        test_pair_rules();
        test_scoreboard();
        test_mem_limit();
        test_flush_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_issue_ctrl.md
Name: id_issue_ctrl

Overview:
- Dual-issue scheduler that sits between the decode FIFO outputs (uop0/uop1 slots) and the execute stage.
- Each cycle it decides how many head uops leave the fetch buffer, using three sources: downstream readiness, intra-pair hazards, and a register scoreboard for long-latency results (memory, mul/div).
- Drives the decoder's read_en, so read_en never takes the invalid 10 encoding.
- Tracks outstanding memory operations to bound in-flight loads/stores.

Parameters:
- MEM_MAX, 2, maximum in-flight memory uops (1..7); counter width is 3 bits.
- NREG, 32, architectural register count; r0 is never marked busy.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- flush  in  1  pipeline flush (exception/mispredict)
- ex_ready  in  1  execute stage accepts uops this cycle
- valid0, valid1  in  1 each  head slot holds a uop (FIFO not empty per slot)
- cls0, cls1  in  2 each  00 alu, 01 mem, 10 muldiv, 11 branch
- wr0, wr1  in  1 each  uop writes rd
- use_j0, use_k0, use_j1, use_k1  in  1 each  uop reads rj/rk
- rd0, rj0, rk0, rd1, rj1, rk1  in  5 each  register fields
- exc0, exc1  in  7 each  exception code of slot (nonzero = exception)
- wb_valid0, wb_valid1  in  1 each  long-latency writeback port valid
- wb_rd0, wb_rd1  in  5 each  writeback destination
- mem_done  in  2  number of memory uops retired this cycle (0..2)
- read_en  out  2  00 none, 01 slot0, 11 both
- issue0, issue1  out  1 each  read_en[0], read_en[1] (mirrors)
- busy_vec  out  32  scoreboard state (debug)

Behaviour:
- read_en, issue0, issue1 are combinational; scoreboard and mem counter are registered.
- Reset state: busy_vec=0, mem_cnt=0. read_en=00 while rstn=0.
- busy_eff(r) = busy[r] & ~(wb_valid0 & wb_rd0==r) & ~(wb_valid1 & wb_rd1==r). Same-cycle writeback releases the register (bypass). busy_eff(0)=0.
- ok0 when all of the following hold:
  - valid0 & ex_ready & ~flush
  - no busy_eff on rj0 if use_j0, on rk0 if use_k0, on rd0 if wr0 (WAW)
  - if cls0==mem: mem_cnt_eff < MEM_MAX, where mem_cnt_eff = mem_cnt - mem_done
- ok1 when ok0 and all of the following hold:
  - valid1
  - exc0==0 and exc1==0
  - cls0 != branch
  - not (cls0==cls1 and cls0 in {mem, muldiv})
  - no RAW: wr0 & rd0!=0 & (use_j1&rj1==rd0 | use_k1&rk1==rd0)
  - no WAW: wr0 & wr1 & rd0==rd1 & rd0!=0
  - slot-1 scoreboard checks identical to slot 0
  - if cls1==mem: mem_cnt_eff < MEM_MAX
- read_en = {ok1, ok0}.
- Scoreboard update at posedge:
  - Clear busy for each wb_valid.
  - Set busy[rd] for each issued uop with wr=1, rd!=0, cls in {mem, muldiv}.
  - Set wins over clear on the same register in the same cycle.
- mem_cnt update: mem_cnt <= mem_cnt - mem_done + (issued mem uops). It must never underflow; an assertion fires if mem_done > mem_cnt.
- flush: the same cycle forces read_en=00. At the next edge, busy_vec<=0 and mem_cnt<=0; wb/mem_done arriving in the flush cycle are ignored.
- Reset asserted mid-operation behaves identically to flush, plus clearing of optional counters.

Optional Feature:
- ISSUE_STAT_EN: adds 32-bit outputs cnt_dual, cnt_single, cnt_stall. Each cycle with rstn=1 & ~flush & valid0:
  - cnt_dual increments on read_en=11
  - cnt_single increments on read_en=01
  - cnt_stall increments on read_en=00
- Counters wrap at 2^32 and are cleared only by reset.
- Without the macro, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Independent ALU pair (rd0=1, rj1=2, rk1=3), ex_ready=1 -> read_en=11 for consecutive cycles, busy_vec stays 0.
- RAW pair: slot0 add rd0=5; slot1 rj1=5 -> read_en=01. Next cycle with the old slot1 now in slot0 -> 01 or 11 as its pair allows.
- Load r7 issued (cls=mem, wr=1) -> busy_vec[7]=1 next cycle. A following use of r7 stalls (read_en=00) until wb_valid0=1, wb_rd0=7, which issues in that same cycle; busy_vec[7] then reads 0.
- MEM_MAX=2: issue two loads in separate cycles, then a third -> read_en=00. Assert mem_done=1 -> third issues the same cycle; mem_cnt stays 2.
- Branch in slot0 or exc1=7'h0B -> read_en=01. Both slots muldiv -> 01. ex_ready=0 -> 00.
- flush with busy_vec=32'h0000_0080 and mem_cnt=1 -> read_en=00 that cycle; next cycle busy_vec=0 and mem_cnt=0. Concurrent wb_valid ignored.
